sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable responder for the SLC-3's asynchronous-style SRAM pin bus (CE, UB, LB, OE, WE, 20-bit address, 16-bit bidirectional data). It answers CPU reads and writes from an on-chip word array, and replaces the simulation-only test memory as a real FPGA target. It also clears the array after reset and exposes a side-band load port, so a bench or boot loader can preload programs while the CPU is idle.

## Interface
Parameters:
- ADDR_W, 8: implemented address bits; DEPTH = 2**ADDR_W words.
- INIT_VALUE, 16'h0000: word written to every location during the post-reset clear.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CE  in  1  chip enable, active-low.
- OE  in  1  output enable, active-low.
- WE  in  1  write enable, active-low.
- UB  in  1  upper-byte lane enable, active-low (I_O[15:8]).
- LB  in  1  lower-byte lane enable, active-low (I_O[7:0]).
- ADDR  in  20  word address from the CPU.
- I_O  inout  16  data bus; the block drives it only as defined under Operation.
- Load_Valid  in  1  load request.
- Load_Addr  in  ADDR_W  load word address.
- Load_Data  in  16  load word.
- Load_Ready  out  1  load accepted on this edge when high together with Load_Valid.
- Init_Busy  out  1  high while the clear sequence runs.

## Operation
- States: S_INIT, S_READY.
- In reset:
  - State is S_INIT and the clear counter is 0.
  - Init_Busy = 1, Load_Ready = 0.
  - I_O is high-Z and the read register is 16'h0000.
- S_INIT:
  - One array write per cycle: word[cnt] <= INIT_VALUE, then cnt++.
  - The transition to S_READY happens on the edge that writes word DEPTH-1.
  - Bus pins and the load port are ignored and I_O stays high-Z.
- S_READY:
  - Init_Busy = 0.
  - Load_Ready = 1 unless a bus write is active this cycle.
- In range means ADDR[19:ADDR_W] == 0.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 16'h0000.
- Bus write (CE=0, WE=0) on an edge:
  - For each lane whose enable is low, that byte of word[ADDR] <= the matching byte of I_O.
  - WE=0 overrides OE: no read and no drive.
- Bus read (CE=0, OE=0, WE=1) on an edge:
  - rd_q <= word[ADDR] (or 0 if out of range).
  - rd_en_q <= 1. In every other case rd_en_q <= 0.
- I_O drive, per lane, combinational gate:
  - A lane drives rd_q when rd_en_q=1 AND CE=0 AND OE=0 AND WE=1 AND that lane's enable=0.
  - Otherwise the lane is high-Z. This guarantees no contention on a read-to-write turnaround.
- Load: Load_Valid && Load_Ready writes word[Load_Addr] <= Load_Data (full word).
- Simultaneous events:
  - A bus write and a load in the same cycle: the bus wins, Load_Ready is low and the load is held.
  - A bus read and a load to the same address: the read returns the old data.
- Reset asserted mid-operation: immediate return to S_INIT and a fresh clear. Any partial write is lost.

## Timing
- Clear takes exactly DEPTH cycles after Reset deasserts. Init_Busy falls on the edge that writes word DEPTH-1.
- Read latency is 1 cycle. With ADDR/OE presented before edge N, data is on I_O after edge N and stays valid while the pins stay unchanged. The CPU's MEM wait state covers this.
- Read data updates every cycle while a read is held, so an address change is reflected one cycle later.
- Writes commit on the edge where CE=0 and WE=0. Read-after-write to the same address, on the next edge, returns the new data.
- Load_Ready is combinational from state and the bus pins. A load commits on the accepting edge.

## Structure
- Package sram_pkg holds:
  - the state enum {S_INIT, S_READY};
  - ADDR_BUS_W = 20 and DATA_W = 16;
  - the default INIT_VALUE.
- Sub-module sram_word_array:
  - DEPTH x 16 storage;
  - one write port with a 2-bit byte enable;
  - one registered read port.
  - The top arbitrates between the clear, bus and load writers into that single write port.
- Tri-state drive stays in the top module, not in the sub-module.

## Test plan
- Clear:
  - Stimulus: release Reset, then count cycles.
  - Required: Init_Busy is high for exactly 256 cycles (ADDR_W=8).
  - Required: a read of 0x00 and of 0xFF then returns 16'h0000.
- Write/read:
  - Stimulus: write 16'hBEEF to 0x12 with UB=LB=0, then read 0x12.
  - Required: I_O=16'hBEEF one cycle after OE is asserted.
- Byte lanes:
  - Stimulus: write 16'h1234 to 0x05 with LB=1, UB=0; then read 0x05 with UB=LB=0.
  - Required: result is 16'h1200.
  - Stimulus: read again with UB=1.
  - Required: I_O[15:8] is Z and I_O[7:0] = 8'h00.
- Out-of-range and turnaround:
  - Stimulus: write 16'hAAAA to 0x00100 with ADDR_W=8.
  - Required: word 0x00 is unchanged, and a read of 0x00100 returns 16'h0000.
  - Stimulus: a read immediately followed by a write.
  - Required: I_O is Z in the WE=0 cycle.
- Load contention:
  - Stimulus: assert Load_Valid (0x20, 16'h5A5A) during a bus write to 0x21.
  - Required: Load_Ready=0 that cycle and the load commits on the next cycle.
  - Required: reads of 0x20 and 0x21 return 16'h5A5A and the bus data.
- Reset mid-clear:
  - Stimulus: assert Reset at clear cycle 100.
  - Required: Init_Busy stays high and the full 256-cycle clear restarts from 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pin-bus responder.
package sram_pkg;

   typedef enum logic {
      S_INIT,
      S_READY
   } state_t;

   localparam int unsigned ADDR_BUS_W = 20;
   localparam int unsigned DATA_W     = 16;

   localparam logic [DATA_W-1:0] INIT_VALUE_DEF = 16'h0000;

endpackage

// File: rtl/sram_word_array.sv
// DEPTH x 16 word store: one byte-enabled write port, one registered read port.
module sram_word_array
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        wr_be,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_in_range,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane writes into the storage array (no reset: the top clears it).
   always_ff @(posedge clk) begin
      if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
      if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
   end

   // Registered read; returns the pre-write word when read and write collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
   end

endmodule

// File: rtl/sram_responder.sv
// Responder for the SLC-3 SRAM pin bus, backed by an on-chip word array,
// with a post-reset clear sequence and a side-band load port.
module sram_responder
   import sram_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 8,
   parameter logic [DATA_W-1:0] INIT_VALUE = INIT_VALUE_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  CE,
   input  logic                  OE,
   input  logic                  WE,
   input  logic                  UB,
   input  logic                  LB,
   input  logic [ADDR_BUS_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0]     I_O,
   input  logic                  Load_Valid,
   input  logic [ADDR_W-1:0]     Load_Addr,
   input  logic [DATA_W-1:0]     Load_Data,
   output logic                  Load_Ready,
   output logic                  Init_Busy
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q;
   logic                rd_en_q;
   logic [DATA_W-1:0]   rd_q;

   logic                bus_wr, bus_rd, in_range;
   logic                drv_hi, drv_lo;

   logic [1:0]          wr_be;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                rd_fire;

   assign bus_wr   = !CE && !WE;
   assign bus_rd   = !CE && !OE && WE;
   assign in_range = (ADDR[ADDR_BUS_W-1:ADDR_W] == '0);

   // State, clear counter and read-valid flag.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_INIT) cnt_q <= cnt_q + 1'b1;
         rd_en_q <= rd_fire;
      end
   end

   // Leave the clear once the last word is being written.
   always_comb begin
      state_d = state_q;
      if (state_q == S_INIT && cnt_q == '1) state_d = S_READY;
   end

   // Status outputs and arbitration of clear / bus / load onto the write port.
   always_comb begin
      Init_Busy  = 1'b1;
      Load_Ready = 1'b0;
      wr_be      = 2'b00;
      wr_addr    = '0;
      wr_data    = '0;
      rd_fire    = 1'b0;
      case (state_q)
         S_INIT: begin
            wr_be   = 2'b11;
            wr_addr = cnt_q;
            wr_data = INIT_VALUE;
         end
         S_READY: begin
            Init_Busy  = 1'b0;
            Load_Ready = !bus_wr;
            rd_fire    = bus_rd;
            if (bus_wr) begin
               // Out-of-range writes still block the load port.
               if (in_range) begin
                  wr_be   = {!UB, !LB};
                  wr_addr = ADDR[ADDR_W-1:0];
                  wr_data = I_O;
               end
            end else if (Load_Valid) begin
               wr_be   = 2'b11;
               wr_addr = Load_Addr;
               wr_data = Load_Data;
            end
         end
         default: ;
      endcase
   end

   sram_word_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk         (Clk),
      .rst_n       (Reset),
      .wr_be       (wr_be),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_en       (rd_fire),
      .rd_in_range (in_range),
      .rd_addr     (ADDR[ADDR_W-1:0]),
      .rd_data     (rd_q)
   );

   // Lanes drive only while the read pins are still held, so WE falling
   // releases the bus in the same cycle.
   assign drv_hi = rd_en_q && bus_rd && !UB;
   assign drv_lo = rd_en_q && bus_rd && !LB;

   assign I_O[15:8] = drv_hi ? rd_q[15:8] : 8'hzz;
   assign I_O[7:0]  = drv_lo ? rd_q[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed cases plus a random
// phase checked against a plain word-array reference model.
module tb_sram_responder;

   localparam int unsigned AW = 8;
   localparam int unsigned NWORDS = 256;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        CE, OE, WE, UB, LB;
   logic [19:0] ADDR;
   logic        Load_Valid;
   logic [7:0]  Load_Addr;
   logic [15:0] Load_Data;
   logic        Load_Ready, Init_Busy;

   // Undriven bus bits read back as 1, so a released lane shows as 8'hFF.
   tri1  [15:0] io_bus;
   logic [15:0] tb_drv;
   logic        tb_drv_en;
   assign io_bus = tb_drv_en ? tb_drv : 16'hzzzz;

   logic [15:0] model [NWORDS];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   sram_responder #(
      .ADDR_W     (AW),
      .INIT_VALUE (16'h0000)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .CE         (CE),
      .OE         (OE),
      .WE         (WE),
      .UB         (UB),
      .LB         (LB),
      .ADDR       (ADDR),
      .I_O        (io_bus),
      .Load_Valid (Load_Valid),
      .Load_Addr  (Load_Addr),
      .Load_Data  (Load_Data),
      .Load_Ready (Load_Ready),
      .Init_Busy  (Init_Busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // What the bus shows for a word read with the given lane enables.
   function automatic logic [15:0] on_bus(input logic [15:0] w, input logic ub, input logic lb);
      return {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
   endfunction

   function automatic bit addr_ok(input logic [19:0] a);
      return a < 20'(NWORDS);
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_pins();
      CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
      tb_drv_en = 1'b0;
      Load_Valid = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NWORDS; i++) model[i] = 16'h0000;
   endtask

   task automatic model_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
      if (addr_ok(a)) begin
         if (!ub) model[a[7:0]][15:8] = d[15:8];
         if (!lb) model[a[7:0]][7:0]  = d[7:0];
      end
   endtask

   task automatic bus_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
      CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = ub; LB = lb; ADDR = a;
      tb_drv = d; tb_drv_en = 1'b1;
      tick();
      model_write(a, d, ub, lb);
      idle_pins();
   endtask

   // Present a read for one edge and return what the bus shows afterwards.
   task automatic bus_read(input logic [19:0] a, input logic ub, input logic lb, output logic [15:0] got);
      CE = 1'b0; WE = 1'b1; OE = 1'b0; UB = ub; LB = lb; ADDR = a;
      tb_drv_en = 1'b0;
      tick();
      got = io_bus;
   endtask

   // Counts edges until Init_Busy drops, bounded.
   task automatic count_clear(output int unsigned n);
      n = 0;
      while (Init_Busy && n < 1000) begin
         tick();
         n++;
      end
   endtask

   logic [15:0] got, exp;
   int unsigned ncyc;

   initial begin
      idle_pins();
      ADDR = '0; Load_Addr = '0; Load_Data = '0; tb_drv = '0;
      Reset = 1'b0;
      model_clear();
      #12;
      check("rst_busy", 32'(Init_Busy), 32'd1);
      check("rst_ready", 32'(Load_Ready), 32'd0);
      check("rst_bus_z", 32'(io_bus), 32'hFFFF);

      // Clear length
      @(posedge Clk); #1;
      Reset = 1'b1;
      count_clear(ncyc);
      check("clear_cycles", ncyc, 32'd256);
      check("ready_after_clear", 32'(Load_Ready), 32'd1);

      bus_read(20'h00, 1'b0, 1'b0, got); idle_pins();
      check("clear_rd_00", 32'(got), 32'h0000);
      bus_read(20'hFF, 1'b0, 1'b0, got); idle_pins();
      check("clear_rd_ff", 32'(got), 32'h0000);

      // Write/read
      bus_write(20'h12, 16'hBEEF, 1'b0, 1'b0);
      bus_read(20'h12, 1'b0, 1'b0, got); idle_pins();
      check("wr_rd_12", 32'(got), 32'hBEEF);

      // Byte lanes
      bus_write(20'h05, 16'h1234, 1'b0, 1'b1);
      bus_read(20'h05, 1'b0, 1'b0, got); idle_pins();
      check("lane_rd_05", 32'(got), 32'h1200);
      bus_read(20'h05, 1'b1, 1'b0, got); idle_pins();
      check("lane_ub_off", 32'(got), 32'hFF00);

      // Out-of-range
      bus_write(20'h00, 16'h0123, 1'b0, 1'b0);
      bus_write(20'h00100, 16'hAAAA, 1'b0, 1'b0);
      bus_read(20'h00, 1'b0, 1'b0, got); idle_pins();
      check("oor_wr_word0", 32'(got), 32'h0123);
      bus_read(20'h00100, 1'b0, 1'b0, got); idle_pins();
      check("oor_rd", 32'(got), 32'h0000);

      // Read then write turnaround: bus must be released as soon as WE falls
      bus_read(20'h12, 1'b0, 1'b0, got);
      check("turn_rd", 32'(got), 32'hBEEF);
      WE = 1'b0;
      #1;
      check("turn_we_z", 32'(io_bus), 32'hFFFF);
      tb_drv = 16'h4321; tb_drv_en = 1'b1;
      tick();
      model_write(20'h12, 16'h4321, 1'b0, 1'b0);
      idle_pins();
      bus_read(20'h12, 1'b0, 1'b0, got); idle_pins();
      check("turn_wr_commit", 32'(got), 32'h4321);

      // Load contention with a bus write
      CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = 20'h21;
      tb_drv = 16'h1357; tb_drv_en = 1'b1;
      Load_Valid = 1'b1; Load_Addr = 8'h20; Load_Data = 16'h5A5A;
      #1;
      check("ld_blocked", 32'(Load_Ready), 32'd0);
      tick();
      model_write(20'h21, 16'h1357, 1'b0, 1'b0);
      CE = 1'b1; WE = 1'b1; tb_drv_en = 1'b0;
      #1;
      check("ld_accept", 32'(Load_Ready), 32'd1);
      tick();
      model[8'h20] = 16'h5A5A;
      idle_pins();
      bus_read(20'h20, 1'b0, 1'b0, got); idle_pins();
      check("ld_rd_20", 32'(got), 32'h5A5A);
      bus_read(20'h21, 1'b0, 1'b0, got); idle_pins();
      check("ld_rd_21", 32'(got), 32'h1357);

      // Random traffic against the reference model
      for (int it = 0; it < 600; it++) begin
         int unsigned op;
         logic [19:0] a;
         logic [15:0] d;
         logic        ub, lb, lv;
         logic [7:0]  la;
         logic [15:0] ld;
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0) a = {12'($urandom_range(1, 4095)), 8'($urandom)};
         else                           a = {12'h000, 8'($urandom)};
         d  = 16'($urandom);
         ub = 1'($urandom);
         lb = 1'($urandom);
         lv = 1'($urandom);
         la = 8'($urandom);
         ld = 16'($urandom);
         idle_pins();
         ADDR = a; UB = ub; LB = lb;
         Load_Valid = lv; Load_Addr = la; Load_Data = ld;
         case (op)
            0: begin CE = 1'b0; WE = 1'b0; tb_drv = d; tb_drv_en = 1'b1; end
            1: begin CE = 1'b0; OE = 1'b0; end
            2: begin CE = 1'b1; OE = 1'($urandom); WE = 1'($urandom); end
            default: begin CE = 1'b0; OE = 1'b1; end
         endcase
         #1;
         check("rnd_ld_ready", 32'(Load_Ready), (op == 0) ? 32'd0 : 32'd1);
         if (op == 1) exp = on_bus(addr_ok(a) ? model[a[7:0]] : 16'h0000, ub, lb);
         else         exp = 16'hFFFF;
         tick();
         if (op != 0) check("rnd_bus", 32'(io_bus), 32'(exp));
         if (op == 0) model_write(a, d, ub, lb);
         else if (lv) model[la] = ld;
      end
      idle_pins();
      for (int i = 0; i < 8; i++) begin
         int unsigned k;
         k = $urandom_range(0, NWORDS - 1);
         bus_read(20'(k), 1'b0, 1'b0, got); idle_pins();
         check("rnd_sweep", 32'(got), 32'(model[k]));
      end

      // Reset during the clear restarts it from word 0
      bus_write(20'hF0, 16'hC0DE, 1'b0, 1'b0);
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      check("mid_busy", 32'(Init_Busy), 32'd1);
      Reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(Init_Busy), 32'd1);
      check("mid_rst_ready", 32'(Load_Ready), 32'd0);
      tick(); tick();
      Reset = 1'b1;
      count_clear(ncyc);
      check("reclear_cycles", ncyc, 32'd256);
      bus_read(20'hF0, 1'b0, 1'b0, got); idle_pins();
      check("reclear_rd_f0", 32'(got), 32'h0000);
      bus_read(20'h12, 1'b0, 1'b0, got); idle_pins();
      check("reclear_rd_12", 32'(got), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
